// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for hazard_stall_ctrl: ID/EX hazard inputs in, stall and flush controls out.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              mem_busy;
  logic              st;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_we;
  logic              ifid_flush;

  // There is no valid/ready pair here. mem_busy is the memory's not-ready, and
  // pc_we/ifid_we/idex_we are the per-stage ready. All of them respond in the
  // same cycle as the inputs, with no registered handshake state.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, mem_busy,
    input  st, pc_we, ifid_we, idex_we, ifid_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, mem_busy,
    output st, pc_we, ifid_we, idex_we, ifid_flush
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 8-bit RISC pipeline: load-use bubbles, taken-branch flush, memory freeze.
// Optional stall performance counter enabled by defining STALL_PERF_EN.
module hazard_stall_ctrl #(
  parameter int REG_AW       = 3,
  parameter int LOAD_BUBBLES = 1
`ifdef STALL_PERF_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus,
  output logic [1:0]         dbg_state
`ifdef STALL_PERF_EN
  , input  logic             perf_clr
  , output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

  localparam logic [3:0] BCNT_INIT = 4'(LOAD_BUBBLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        bcnt;
  logic [3:0]        bcnt_nxt;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              load_use;
  logic              st;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_we;
  logic              ifid_flush;

  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;
  assign ex_rd  = bus.ex_rd;

  // Register 0 is compared like any other; this core has no hardwired zero.
  assign load_use = bus.ex_mem_read &
                    ((bus.id_use_rs1 & (ex_rd == id_rs1)) |
                     (bus.id_use_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bcnt_nxt   = bcnt;
    st         = 1'b0;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    ifid_flush = 1'b0;
    if (!rst_n) begin
      st        = 1'b1;
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      state_nxt = RUN;
      bcnt_nxt  = '0;
    end else if (state == BUBBLE) begin
      // EX already holds a bubble here, so branch_taken cannot be live.
      if (bus.mem_busy) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
      end else begin
        st       = 1'b1;
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        bcnt_nxt = bcnt - 4'd1;
        if (bcnt <= 4'd1) begin
          state_nxt = RUN;
          bcnt_nxt  = '0;
        end
      end
    end else if (bus.mem_busy) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      state_nxt = FREEZE;
    end else if (bus.branch_taken) begin
      // The ID instruction is wrong-path, so its load-use hazard does not matter.
      st         = 1'b1;
      ifid_flush = 1'b1;
      state_nxt  = RUN;
    end else if (load_use) begin
      st      = 1'b1;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      if (LOAD_BUBBLES == 1) begin
        state_nxt = RUN;
      end else begin
        state_nxt = BUBBLE;
        bcnt_nxt  = BCNT_INIT;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  assign bus.st         = st;
  assign bus.pc_we      = pc_we;
  assign bus.ifid_we    = ifid_we;
  assign bus.idex_we    = idex_we;
  assign bus.ifid_flush = ifid_flush;
  assign dbg_state      = state;

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_stall_cnt <= '0;
    end else if (!pc_we && (perf_stall_cnt != {CNT_W{1'b1}})) begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
